cw_trace_reader: RTL
====================

Name: cw_trace_reader

Overview:
- Read-side counterpart of the ChipWatcher trigger/capture core.
- Owns the trace RAM that the core writes through wt_ce/wt_en/wt_addr.
- After a capture session ends, replays the stored samples oldest-first on a valid/ready stream. The L2-Switch debug path, a UART/host bridge, consumes that stream.
- Single clock domain: trig_clk.

Parameters:
DATA_WIDTH, 7, width of one captured sample; matches the watched bus_din width.
ADDR_WIDTH, 10, trace depth is 2**ADDR_WIDTH. The block uses only wt_addr[ADDR_WIDTH-1:0].

Ports:
trig_clk  in  1  sole clock; capture and readout both run on it
jrstn  in  1  asynchronous active-low reset
wt_ce  in  1  capture session active, from the capture core
wt_en  in  1  sample write strobe, from the capture core
wt_addr  in  16  sample write address, from the capture core
wt_data  in  DATA_WIDTH  sample value written at wt_addr
rd_start  in  1  single-cycle request to begin readout
rd_busy  out  1  readout in progress
rd_data  out  DATA_WIDTH  sample value
rd_index  out  ADDR_WIDTH  ordinal of the sample; 0 is the oldest
rd_valid  out  1  rd_data, rd_index and rd_last are valid
rd_ready  in  1  consumer accepts the current beat
rd_last  out  1  current beat is the final sample
rd_done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: rd_busy, rd_valid, rd_last and rd_done = 0. rd_data and rd_index = 0. count = 0, wrapped = 0, state = IDLE. RAM contents are not reset.
- Session bookkeeping:
  - A rising edge of wt_ce (registered compare) clears count and wrapped.
  - A write occurs when wt_ce & wt_en: mem[wt_addr[AW-1:0]] <= wt_data, and last_addr <= that address.
  - The first write of a session also sets first_addr.
  - count increments on each write and saturates at DEPTH; reaching DEPTH sets wrapped.
  - wt_en while wt_ce = 0 is ignored.
- Start address and length:
  - wrapped = 0: start = first_addr, N = count.
  - wrapped = 1: start = (last_addr + 1) mod DEPTH, N = DEPTH.
  - Read addresses increment modulo DEPTH.
- FSM states: IDLE, PREFETCH, STREAM, FLUSH.
- IDLE:
  - rd_start with wt_ce = 1: ignored.
  - rd_start with count = 0: rd_done pulses on the next cycle; no beats; stay IDLE.
  - Otherwise: latch start and N, set rd_busy, go to PREFETCH.
- PREFETCH: issue the synchronous RAM read of the first address, then go to STREAM.
- Timing: rd_valid first rises exactly 2 cycles after the rd_start cycle. RAM read latency is 1 cycle. The output register plus a 1-entry skid buffer sustain 1 beat per cycle while rd_ready is held high.
- Handshake rules:
  - A beat transfers when rd_valid & rd_ready.
  - While rd_valid = 1 and rd_ready = 0, rd_data, rd_index and rd_last hold stable.
  - rd_valid never drops without a transfer, except on abort.
  - rd_index runs 0..N-1 in order with no gaps or duplicates.
  - rd_last = 1 only on the beat with index N-1.
- After the last read is issued, the FSM enters FLUSH and drains the output register and skid. On transfer of the last beat, rd_busy clears and rd_done pulses on the next cycle; return to IDLE.
- rd_start while busy: ignored.
- Abort: wt_ce rising while busy returns to IDLE on the next cycle. rd_valid, rd_busy and rd_last clear; rd_done does not pulse. New-session bookkeeping proceeds normally.
- Same-cycle write and read to the same RAM address cannot happen, because writes need wt_ce = 1, which aborts readout.
- jrstn assertion mid-readout: all outputs go to their reset values immediately (asynchronous).
- A second readout of the same session, with no new wt_ce rise, replays identical data.

Test Plan:
- Write 5 samples 0x11..0x15 at addresses 20..24, drop wt_ce, pulse rd_start, rd_ready = 1 -> rd_valid rises 2 cycles later. Beats are 0x11..0x15 with index 0..4 on 5 consecutive cycles. rd_last on 0x15; rd_done 1 cycle after.
- Write 1030 samples, value = write ordinal mod 128, addresses incrementing from 0 with wrap -> wrapped = 1. Readout starts at address 6 and returns 1024 beats; first value is ordinal 6 mod 128 and last is 1029 mod 128 = 5. rd_last only on index 1023.
- Repeat scenario 1 with rd_ready toggling 1,0,0,1,... -> no lost or duplicated beats; outputs stable while stalled; same 5 values in order.
- rd_start with no writes since the last wt_ce rise -> rd_done pulse 1 cycle later; rd_valid never asserts.
- Raise wt_ce after beat 2 of a 5-sample readout -> rd_valid and rd_busy are 0 the next cycle and no rd_done. rd_start while wt_ce = 1 is ignored.
- Assert jrstn low mid-stream -> all outputs 0 immediately. After release, rd_start returns rd_done only, since count = 0.

Source files
------------

// File: rtl/cw_trace_reader.sv
// -----------------------------------------------------------------------------
// cw_trace_reader
//   Read side of the ChipWatcher trigger/capture core. Holds the trace RAM the
//   capture core fills, and once a capture session has ended, replays the
//   stored samples oldest-first on a valid/ready stream.
//
// Ports (all synchronous to trig_clk):
//   trig_clk   sole clock for capture and readout
//   jrstn      asynchronous active-low reset
//   wt_ce      capture session active (a rising edge opens a new session)
//   wt_en      sample write strobe, honoured only while wt_ce = 1
//   wt_addr    sample write address; only the low ADDR_WIDTH bits are used
//   wt_data    sample value written at wt_addr
//   rd_start   single-cycle request to begin a readout
//   rd_busy    readout in progress
//   rd_data    sample value of the current beat
//   rd_index   ordinal of the current beat, 0 = oldest sample
//   rd_valid   rd_data / rd_index / rd_last are valid
//   rd_ready   consumer accepts the current beat
//   rd_last    current beat is the final sample
//   rd_done    one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module cw_trace_reader #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  trig_clk,
  input  logic                  jrstn,
  input  logic                  wt_ce,
  input  logic                  wt_en,
  input  logic [15:0]           wt_addr,
  input  logic [DATA_WIDTH-1:0] wt_data,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_index,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  rd_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_STREAM   = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Trace RAM and capture-session bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  wt_ce_d_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  wrapped_r;
  logic [ADDR_WIDTH-1:0] first_addr_r;
  logic [ADDR_WIDTH-1:0] last_addr_r;

  logic                  ce_rise_s;
  logic                  wr_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [ADDR_WIDTH:0]   base_count_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  wrapped_nxt_s;
  logic                  first_wr_s;
  logic                  unused_s;

  assign ce_rise_s = wt_ce & ~wt_ce_d_r;
  assign wr_s      = wt_ce & wt_en;
  assign wr_addr_s = wt_addr[ADDR_WIDTH-1:0];
  assign unused_s  = ^wt_addr[15:ADDR_WIDTH];

  // A write in the very cycle wt_ce rises already belongs to the new session,
  // so the cleared count is the base for that write.
  assign base_count_s = ce_rise_s ? CNT_ZERO : count_r;
  assign first_wr_s   = wr_s & (base_count_s == CNT_ZERO);

  // Next count/wrapped: saturating sample count, wrapped once the RAM is full
  always_comb begin
    count_nxt_s   = base_count_s;
    wrapped_nxt_s = ce_rise_s ? 1'b0 : wrapped_r;
    if (wr_s) begin
      if (base_count_s != CNT_FULL) begin
        count_nxt_s = base_count_s + CNT_ONE;
      end else begin
        count_nxt_s = base_count_s;
      end
      if ((base_count_s + CNT_ONE) >= CNT_FULL) begin
        wrapped_nxt_s = 1'b1;
      end else begin
        wrapped_nxt_s = wrapped_nxt_s;
      end
    end else begin
      count_nxt_s = base_count_s;
    end
  end

  // Session bookkeeping registers
  always_ff @(posedge trig_clk or negedge jrstn) begin
    if (!jrstn) begin
      wt_ce_d_r    <= 1'b0;
      count_r      <= CNT_ZERO;
      wrapped_r    <= 1'b0;
      first_addr_r <= ADDR_ZERO;
      last_addr_r  <= ADDR_ZERO;
    end else begin
      wt_ce_d_r <= wt_ce;
      count_r   <= count_nxt_s;
      wrapped_r <= wrapped_nxt_s;
      if (wr_s) begin
        last_addr_r <= wr_addr_s;
      end
      if (first_wr_s) begin
        first_addr_r <= wr_addr_s;
      end
    end
  end

  // Trace RAM write port (contents deliberately not reset)
  always_ff @(posedge trig_clk) begin
    if (wr_s) begin
      mem_r[wr_addr_s] <= wt_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Readout FSM and output pipeline (output register + 1-entry skid)
  // ---------------------------------------------------------------------------
  state_t                state_r;
  state_t                state_nxt_s;

  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH-1:0] issue_idx_r;
  logic [ADDR_WIDTH:0]   n_r;

  logic                  rd_busy_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [ADDR_WIDTH-1:0] rd_index_r;
  logic                  rd_last_r;
  logic                  rd_done_r;

  logic                  skid_v_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic [ADDR_WIDTH-1:0] skid_index_r;
  logic                  skid_last_r;

  logic                  xfer_s;
  logic                  last_issue_s;
  logic                  abort_s;
  logic                  start_req_s;
  logic                  start_ok_s;
  logic                  empty_start_s;
  logic                  issue_s;
  logic                  final_xfer_s;
  logic [DATA_WIDTH-1:0] ram_rd_s;

  assign xfer_s        = rd_valid_r & rd_ready;
  assign last_issue_s  = ({1'b0, issue_idx_r} == (n_r - CNT_ONE));
  assign abort_s       = ce_rise_s & (state_r != S_IDLE);
  assign start_req_s   = (state_r == S_IDLE) & rd_start & ~wt_ce;
  assign start_ok_s    = start_req_s & (count_r != CNT_ZERO);
  assign empty_start_s = start_req_s & (count_r == CNT_ZERO);
  assign final_xfer_s  = (state_r == S_FLUSH) & xfer_s & rd_last_r;
  assign ram_rd_s      = mem_r[rd_addr_r];

  // FSM state register
  always_ff @(posedge trig_clk or negedge jrstn) begin
    if (!jrstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and RAM read issue. A read is only issued while the skid
  // is empty, so the word it returns always has a register to land in; this
  // keeps rd_ready out of the RAM address path.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = S_PREFETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PREFETCH: begin
        issue_s     = 1'b1;
        state_nxt_s = last_issue_s ? S_FLUSH : S_STREAM;
      end
      S_STREAM: begin
        if (!skid_v_r) begin
          issue_s     = 1'b1;
          state_nxt_s = last_issue_s ? S_FLUSH : S_STREAM;
        end else begin
          state_nxt_s = S_STREAM;
        end
      end
      S_FLUSH: begin
        if (final_xfer_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
    if (abort_s) begin
      state_nxt_s = S_IDLE;
      issue_s     = 1'b0;
    end else begin
      issue_s = issue_s;
    end
  end

  // Readout datapath: start latch, read address, output register and skid
  always_ff @(posedge trig_clk or negedge jrstn) begin
    if (!jrstn) begin
      rd_addr_r    <= ADDR_ZERO;
      issue_idx_r  <= ADDR_ZERO;
      n_r          <= CNT_ZERO;
      rd_busy_r    <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_data_r    <= DATA_ZERO;
      rd_index_r   <= ADDR_ZERO;
      rd_last_r    <= 1'b0;
      rd_done_r    <= 1'b0;
      skid_v_r     <= 1'b0;
      skid_data_r  <= DATA_ZERO;
      skid_index_r <= ADDR_ZERO;
      skid_last_r  <= 1'b0;
    end else begin
      rd_done_r <= 1'b0;
      if (abort_s) begin
        rd_busy_r  <= 1'b0;
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
        skid_v_r   <= 1'b0;
      end else begin
        if (start_ok_s) begin
          // Oldest sample sits just after the newest once the RAM has wrapped.
          rd_addr_r   <= wrapped_r ? (last_addr_r + ADDR_ONE) : first_addr_r;
          n_r         <= wrapped_r ? CNT_FULL : count_r;
          issue_idx_r <= ADDR_ZERO;
          rd_busy_r   <= 1'b1;
        end else if (empty_start_s) begin
          rd_done_r <= 1'b1;
        end

        if (issue_s) begin
          rd_addr_r   <= rd_addr_r + ADDR_ONE;
          issue_idx_r <= issue_idx_r + ADDR_ONE;
        end

        if (!rd_valid_r || xfer_s) begin
          if (skid_v_r) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= skid_data_r;
            rd_index_r <= skid_index_r;
            rd_last_r  <= skid_last_r;
            skid_v_r   <= 1'b0;
          end else if (issue_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= ram_rd_s;
            rd_index_r <= issue_idx_r;
            rd_last_r  <= last_issue_s;
          end else begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
          end
        end else if (issue_s) begin
          skid_v_r     <= 1'b1;
          skid_data_r  <= ram_rd_s;
          skid_index_r <= issue_idx_r;
          skid_last_r  <= last_issue_s;
        end

        if (final_xfer_s) begin
          rd_busy_r <= 1'b0;
          rd_done_r <= 1'b1;
        end
      end
    end
  end

  assign rd_busy  = rd_busy_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_index = rd_index_r;
  assign rd_last  = rd_last_r;
  assign rd_done  = rd_done_r;

endmodule
